// File: rtl/rst_seq.sv
// Reset sequencer and run monitor: holds N_CH reset channels, releases them in a
// staggered order, then counts run cycles until CPU halt or the cycle budget expires.
module rst_seq #(
    parameter int SIM            = 0,
    parameter int RST_CYCLES_HW  = 1000000,
    parameter int RST_CYCLES_SIM = 25,
    parameter int N_CH           = 3,
    parameter int STAGGER        = 4,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int AUTO_RESTART   = 0
) (
    input  logic             EXCLK,
    input  logic             btnC,
    input  logic             sw_rst,
    input  logic             halt,
    output logic [N_CH-1:0]  rst_out,
    output logic             run,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             halted,
    output logic             timeout
);

    localparam int R  = (SIM != 0) ? RST_CYCLES_SIM : RST_CYCLES_HW;
    localparam int L  = R + (N_CH - 1) * STAGGER;
    localparam int HW = $clog2(L + 1);

    localparam logic [HW-1:0] R_H = HW'(R);
    localparam logic [HW-1:0] L_H = HW'(L);

    // A budget wider than the counter can never be hit, so it behaves as disabled.
    localparam bit T_REACH = (TIMEOUT_CYCLES != 0) &&
                             ((CNT_W >= 32) || ((TIMEOUT_CYCLES >> CNT_W) == 0));
    localparam logic [CNT_W-1:0] T_VAL   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {HOLD, RELEASE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_CH-1:0]  rst_d;
    logic             run_d;
    logic [CNT_W-1:0] cnt_d;
    logic             halted_d, timeout_d;
    logic             restart;

    function automatic logic [HW-1:0] thr(input int k);
        return HW'(R + k * STAGGER);
    endfunction

    always_ff @(posedge EXCLK) begin
        if (btnC) begin
            state_q   <= HOLD;
            hold_q    <= '0;
            rst_out   <= '1;
            run       <= 1'b0;
            cycle_cnt <= '0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rst_out   <= rst_d;
            run       <= run_d;
            cycle_cnt <= cnt_d;
            halted    <= halted_d;
            timeout   <= timeout_d;
        end
    end

    // Outputs are computed from the next state so they stay fully registered.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cycle_cnt;
        halted_d  = halted;
        timeout_d = timeout;
        restart   = 1'b0;
        rst_d     = '0;

        if (sw_rst) begin
            restart = 1'b1;
        end else begin
            case (state_q)
                HOLD, RELEASE: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_d == L_H)
                        state_d = RUN;
                    else if (hold_d >= R_H)
                        state_d = RELEASE;
                end
                RUN: begin
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = DONE;
                    end else if (cycle_cnt != CNT_MAX) begin
                        cnt_d = cycle_cnt + 1'b1;
                        if (T_REACH && (cnt_d == T_VAL)) begin
                            timeout_d = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                DONE: begin
                    if (AUTO_RESTART != 0)
                        restart = 1'b1;
                end
                default: state_d = HOLD;
            endcase
        end

        if (restart) begin
            state_d   = HOLD;
            hold_d    = '0;
            cnt_d     = '0;
            halted_d  = 1'b0;
            timeout_d = 1'b0;
        end

        for (int k = 0; k < N_CH; k++)
            rst_d[k] = ((state_d == HOLD) || (state_d == RELEASE)) && (hold_d < thr(k));
        run_d = (state_d == RUN);
    end

endmodule
